// File: rtl/sifive_reset_sequencer.sv
// rtl/sifive_reset_sequencer.sv - staged reset release sequencer with ready gating and restart
module sifive_reset_sequencer #(
  parameter int CHANNELS      = 4,
  parameter int SYNC_STAGES   = 4,
  parameter int DEBOUNCE_BITS = 8,
  parameter int STAGE_GAP     = 16,
  parameter int TIMEOUT_BITS  = 16,
  parameter int REQ_FILTER    = 4,
  localparam int SW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                req_async,
  input  logic [CHANNELS-1:0] ready_async,
  output logic [CHANNELS-1:0] rst_out,
  output logic                done,
  output logic                err_timeout,
  output logic [SW-1:0]       timeout_stage,
  output logic [7:0]          restart_count
);

  localparam int GW   = $clog2(STAGE_GAP + 1);
  localparam int CW_A = (DEBOUNCE_BITS > TIMEOUT_BITS) ? DEBOUNCE_BITS : TIMEOUT_BITS;
  localparam int CW   = (CW_A > GW) ? CW_A : GW;
  localparam int FW   = (REQ_FILTER > 1) ? $clog2(REQ_FILTER) : 1;

  localparam logic [CW-1:0] HOLD_LAST  = CW'((64'd1 << DEBOUNCE_BITS) - 64'd1);
  localparam logic [CW-1:0] WAIT_LAST  = CW'((64'd1 << TIMEOUT_BITS) - 64'd1);
  localparam logic [CW-1:0] GAP_LAST   = CW'(STAGE_GAP - 1);
  localparam logic [FW-1:0] FILT_LAST  = FW'(REQ_FILTER - 1);
  localparam logic [SW-1:0] LAST_STAGE = SW'(CHANNELS - 1);

  typedef enum logic [1:0] {HOLD, WAIT_RDY, GAP, DONE} state_t;

  logic [SYNC_STAGES-1:0] req_sync;
  logic [CHANNELS-1:0]    rdy_sync [SYNC_STAGES];
  logic [FW-1:0]          req_run;
  logic                   req_s;
  logic                   req_f;
  logic [CHANNELS-1:0]    rdy;
  logic                   lost;
  logic                   timeout;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [SW-1:0] stage;

  assign req_s   = req_sync[SYNC_STAGES-1];
  assign rdy     = rdy_sync[SYNC_STAGES-1];
  // req_run holds how many earlier consecutive samples were high, so the
  // filter fires on the same edge that sees the REQ_FILTER-th high sample
  assign req_f   = req_s && (req_run == FILT_LAST);
  assign lost    = |(~rdy & ~rst_out);
  assign timeout = (state == WAIT_RDY) && !rdy[stage] && (cnt == WAIT_LAST);

  always_ff @(posedge clock) begin
    if (reset) begin
      req_sync <= '0;
      req_run  <= '0;
      for (int i = 0; i < SYNC_STAGES; i++) rdy_sync[i] <= '0;
    end else begin
      req_sync    <= {req_sync[SYNC_STAGES-2:0], req_async};
      rdy_sync[0] <= ready_async;
      for (int i = 1; i < SYNC_STAGES; i++) rdy_sync[i] <= rdy_sync[i-1];
      if (!req_s) req_run <= '0;
      else if (req_run != FILT_LAST) req_run <= req_run + FW'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state         <= HOLD;
      cnt           <= '0;
      stage         <= '0;
      rst_out       <= '1;
      done          <= 1'b0;
      err_timeout   <= 1'b0;
      timeout_stage <= '0;
      restart_count <= '0;
    end else if (state != HOLD && (req_f || lost || timeout)) begin
      state   <= HOLD;
      cnt     <= '0;
      stage   <= '0;
      rst_out <= '1;
      done    <= 1'b0;
      // a coincident request or ready loss outranks the timeout
      if (!req_f && !lost) begin
        err_timeout   <= 1'b1;
        timeout_stage <= stage;
      end
      if (restart_count != 8'hff) restart_count <= restart_count + 8'd1;
    end else begin
      case (state)
        HOLD: begin
          if (req_f) cnt <= '0;
          else if (cnt == HOLD_LAST) begin
            state <= WAIT_RDY;
            cnt   <= '0;
            stage <= '0;
          end else cnt <= cnt + CW'(1);
        end
        WAIT_RDY: begin
          if (rdy[stage]) begin
            rst_out[stage] <= 1'b0;
            if (stage == LAST_STAGE) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              state <= GAP;
              cnt   <= '0;
            end
          end else cnt <= cnt + CW'(1);
        end
        GAP: begin
          if (cnt == GAP_LAST) begin
            stage <= stage + SW'(1);
            state <= WAIT_RDY;
            cnt   <= '0;
          end else cnt <= cnt + CW'(1);
        end
        DONE: begin
          done    <= 1'b1;
          rst_out <= '0;
        end
        default: state <= HOLD;
      endcase
    end
  end

endmodule

// File: tb/tb_sifive_reset_sequencer.sv
// tb/tb_sifive_reset_sequencer.sv - bench for sifive_reset_sequencer against a deadline-based model
module tb_sifive_reset_sequencer;

  localparam int C = 3, S = 2, D = 4, G = 2, T = 5, F = 4;
  localparam int M_HOLD = 0, M_WAIT = 1, M_GAP = 2, M_DONE = 3;

  logic         clock = 1'b0;
  logic         reset = 1'b1;
  logic         req_async = 1'b0;
  logic [C-1:0] ready_async = '0;
  logic [C-1:0] rst_out;
  logic         done;
  logic         err_timeout;
  logic [1:0]   timeout_stage;
  logic [7:0]   restart_count;

  int n_checks = 0;
  int n_fail   = 0;
  int e        = 0;

  sifive_reset_sequencer #(
    .CHANNELS(C), .SYNC_STAGES(S), .DEBOUNCE_BITS(D),
    .STAGE_GAP(G), .TIMEOUT_BITS(T), .REQ_FILTER(F)
  ) dut (
    .clock(clock), .reset(reset), .req_async(req_async), .ready_async(ready_async),
    .rst_out(rst_out), .done(done), .err_timeout(err_timeout),
    .timeout_stage(timeout_stage), .restart_count(restart_count)
  );

  always #5 clock = ~clock;

  // Model: raw input history since reset, released-stage count and an absolute deadline edge
  logic [C-1:0] h_rdy[$];
  logic         h_req[$];
  int   m_n, m_mode, m_rel, m_dl, m_ts, m_rc;
  logic m_err;
  bit   m_valid = 0;

  function automatic logic s_rdy(int j);
    int idx = m_n - S;
    if (idx < 1) return 1'b0;
    return h_rdy[idx-1][j];
  endfunction

  function automatic logic s_reqf();
    for (int k = 0; k < F; k++) begin
      int idx = m_n - S - k;
      if (idx < 1) return 1'b0;
      if (!h_req[idx-1]) return 1'b0;
    end
    return 1'b1;
  endfunction

  function automatic logic [C-1:0] exp_rst();
    logic [C-1:0] v = '1;
    for (int j = 0; j < m_rel; j++) v[j] = 1'b0;
    return v;
  endfunction

  task automatic model_step();
    logic rf, lost, to;
    if (reset) begin
      m_n = 0; h_rdy.delete(); h_req.delete();
      m_mode = M_HOLD; m_rel = 0; m_dl = 1 << D;
      m_err = 1'b0; m_ts = 0; m_rc = 0; m_valid = 1;
      return;
    end
    m_n++;
    h_rdy.push_back(ready_async);
    h_req.push_back(req_async);
    rf = s_reqf();
    if (m_mode != M_HOLD) begin
      lost = 1'b0;
      for (int j = 0; j < m_rel; j++) if (!s_rdy(j)) lost = 1'b1;
      to = (m_mode == M_WAIT) && !s_rdy(m_rel) && (m_n == m_dl);
      if (rf || lost || to) begin
        if (!rf && !lost) begin m_err = 1'b1; m_ts = m_rel; end
        if (m_rc < 255) m_rc++;
        m_mode = M_HOLD; m_rel = 0; m_dl = m_n + (1 << D);
        return;
      end
    end
    case (m_mode)
      M_HOLD: begin
        if (rf) m_dl = m_n + (1 << D);
        else if (m_n == m_dl) begin m_mode = M_WAIT; m_dl = m_n + (1 << T); end
      end
      M_WAIT: begin
        if (s_rdy(m_rel)) begin
          m_rel++;
          if (m_rel == C) m_mode = M_DONE;
          else begin m_mode = M_GAP; m_dl = m_n + G; end
        end
      end
      M_GAP: if (m_n == m_dl) begin m_mode = M_WAIT; m_dl = m_n + (1 << T); end
      default: ;
    endcase
  endtask

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  initial forever begin
    @(posedge clock);
    model_step();
  end

  initial forever begin
    @(negedge clock);
    if (m_valid) begin
      check("cyc_rst_out", 32'(rst_out), 32'(exp_rst()));
      check("cyc_done", 32'(done), 32'(m_mode == M_DONE));
      check("cyc_err_timeout", 32'(err_timeout), 32'(m_err));
      check("cyc_timeout_stage", 32'(timeout_stage), 32'(m_ts));
      check("cyc_restart_count", 32'(restart_count), 32'(m_rc));
    end
  end

  task automatic goto_edge(int target);
    repeat (target - e) @(negedge clock);
    e = target;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    e = 0;
  endtask

  initial begin
    int act, j;
    @(negedge clock);

    // all ready before release
    ready_async = 3'b111;
    do_reset();
    goto_edge(16); check("s1_rst16", 32'(rst_out), 32'b111);
    goto_edge(17); check("s1_rst17", 32'(rst_out), 32'b110);
    check("s1_model_rst17", 32'(exp_rst()), 32'b110);
    goto_edge(19); check("s1_rst19", 32'(rst_out), 32'b110);
    goto_edge(20); check("s1_rst20", 32'(rst_out), 32'b100);
    goto_edge(22); check("s1_rst22", 32'(rst_out), 32'b100);
    check("s1_done22", 32'(done), 32'd0);
    goto_edge(23); check("s1_rst23", 32'(rst_out), 32'b000);
    check("s1_done23", 32'(done), 32'd1);
    check("s1_rc23", 32'(restart_count), 32'd0);

    // stage 1 never ready: timeout loop
    ready_async = 3'b101;
    do_reset();
    goto_edge(17); check("s2_rst17", 32'(rst_out), 32'b110);
    goto_edge(50); check("s2_rst50", 32'(rst_out), 32'b110);
    check("s2_err50", 32'(err_timeout), 32'd0);
    goto_edge(51); check("s2_rst51", 32'(rst_out), 32'b111);
    check("s2_err51", 32'(err_timeout), 32'd1);
    check("s2_ts51", 32'(timeout_stage), 32'd1);
    check("s2_rc51", 32'(restart_count), 32'd1);
    check("s2_model_rc51", 32'(m_rc), 32'd1);
    goto_edge(67); check("s2_rst67", 32'(rst_out), 32'b111);
    goto_edge(68); check("s2_rst68", 32'(rst_out), 32'b110);
    goto_edge(101); check("s2_rst101", 32'(rst_out), 32'b110);
    goto_edge(102); check("s2_rst102", 32'(rst_out), 32'b111);
    check("s2_rc102", 32'(restart_count), 32'd2);
    ready_async = 3'b111;
    goto_edge(130); check("s2_done130", 32'(done), 32'd1);
    check("s2_err_kept", 32'(err_timeout), 32'd1);
    check("s2_ts_kept", 32'(timeout_stage), 32'd1);

    // request pulses in DONE
    req_async = 1'b1;
    goto_edge(133);
    req_async = 1'b0;
    goto_edge(140); check("s3_short_rst", 32'(rst_out), 32'b000);
    check("s3_short_rc", 32'(restart_count), 32'd2);
    req_async = 1'b1;
    goto_edge(145); check("s3_rst145", 32'(rst_out), 32'b000);
    goto_edge(146); check("s3_rst146", 32'(rst_out), 32'b111);
    check("s3_rc146", 32'(restart_count), 32'd3);
    goto_edge(150);
    req_async = 1'b0;
    goto_edge(168); check("s3_frozen168", 32'(rst_out), 32'b111);
    goto_edge(169); check("s3_rst169", 32'(rst_out), 32'b110);
    goto_edge(175); check("s3_done175", 32'(done), 32'd1);
    check("s3_rc175", 32'(restart_count), 32'd3);

    // one-cycle ready loss in DONE
    goto_edge(180);
    ready_async = 3'b110;
    goto_edge(181);
    ready_async = 3'b111;
    goto_edge(182); check("s4_rst182", 32'(rst_out), 32'b000);
    goto_edge(183); check("s4_rst183", 32'(rst_out), 32'b111);
    check("s4_done183", 32'(done), 32'd0);
    check("s4_rc183", 32'(restart_count), 32'd4);
    goto_edge(199); check("s4_rst199", 32'(rst_out), 32'b111);
    goto_edge(200); check("s4_rst200", 32'(rst_out), 32'b110);

    // reset during GAP
    reset = 1'b1;
    goto_edge(201);
    check("s5_rst", 32'(rst_out), 32'b111);
    check("s5_done", 32'(done), 32'd0);
    check("s5_err", 32'(err_timeout), 32'd0);
    check("s5_ts", 32'(timeout_stage), 32'd0);
    check("s5_rc", 32'(restart_count), 32'd0);
    reset = 1'b0;
    e = 0;
    goto_edge(16); check("s5_rst16", 32'(rst_out), 32'b111);
    goto_edge(17); check("s5_rst17", 32'(rst_out), 32'b110);
    goto_edge(20); check("s5_rst20", 32'(rst_out), 32'b100);
    goto_edge(23); check("s5_rst23", 32'(rst_out), 32'b000);
    check("s5_done23", 32'(done), 32'd1);

    // randomized disturbances, checked every cycle against the model
    for (int it = 0; it < 80; it++) begin
      act = $urandom_range(0, 7);
      j   = $urandom_range(0, C-1);
      case (act)
        4: begin req_async = 1'b1; repeat ($urandom_range(1, 8)) @(negedge clock); req_async = 1'b0; end
        5: begin ready_async[j] = 1'b0; repeat ($urandom_range(1, 4)) @(negedge clock); ready_async[j] = 1'b1; end
        6: begin ready_async[j] = 1'b0; repeat ($urandom_range(20, 60)) @(negedge clock); ready_async[j] = 1'b1; end
        7: begin reset = 1'b1; @(negedge clock); reset = 1'b0; end
        default: repeat ($urandom_range(10, 60)) @(negedge clock);
      endcase
    end
    repeat (100) @(negedge clock);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sifive_reset_sequencer.md
# sifive_reset_sequencer

Parametrised multi-stage reset sequencer for FPGA shells. It releases `CHANNELS` reset outputs one at a time, all in one clock domain. Each stage is released only after its own ready input (MMCM lock, DDR calibration done, etc.) is seen. An initial hold period and a programmable gap separate the releases. A debounced external reset request, the loss of a ready that had already been used, or a ready timeout restarts the whole sequence. It sits after the board-level power/lock reset and drives the per-subsystem resets of the design.

## Interface
- `CHANNELS`, 4: number of reset stages (≥1).
- `SYNC_STAGES`, 4: synchroniser depth for `req_async` and `ready_async` (≥2).
- `DEBOUNCE_BITS`, 8: initial hold lasts 2^DEBOUNCE_BITS cycles.
- `STAGE_GAP`, 16: cycles spent in GAP between stage releases (≥1).
- `TIMEOUT_BITS`, 16: maximum wait for a ready is 2^TIMEOUT_BITS cycles.
- `REQ_FILTER`, 4: number of consecutive high synchronised samples needed to accept a request (≥1).
- `clock` in 1: single clock.
- `reset` in 1: synchronous, active-high.
- `req_async` in 1: external reset request (button or software), asynchronous, active-high.
- `ready_async` in CHANNELS: per-stage ready, asynchronous; bit i gates stage i.
- `rst_out` out CHANNELS: active-high stage resets, registered.
- `done` out 1: all stages released.
- `err_timeout` out 1: sticky; a ready wait has timed out.
- `timeout_stage` out max(1,$clog2(CHANNELS)): index of the stage that last timed out.
- `restart_count` out 8: number of restarts, saturating at 255.

## Operation
- Input conditioning:
  - `req_async` and each `ready_async` bit pass through `SYNC_STAGES` flops, cleared by `reset`.
  - `req_f` goes high once synchronised req has been high for `REQ_FILTER` consecutive cycles. It stays high while synchronised req stays high and clears on the first low sample.
- FSM states: HOLD, WAIT_RDY, GAP, DONE. Registers: `cnt` (wide enough for the largest count) and `stage`.
- Reset values: state=HOLD, cnt=0, stage=0, rst_out all 1, done=0, err_timeout=0, timeout_stage=0, restart_count=0.
- HOLD:
  - All rst_out are 1.
  - While `req_f`=1, cnt is held at 0.
  - Otherwise cnt increments. On the cycle with cnt = 2^DEBOUNCE_BITS−1, go to WAIT_RDY with cnt=0 and stage=0.
- WAIT_RDY:
  - If synchronised ready[stage]=1: rst_out[stage] goes to 0. If stage = CHANNELS−1, go to DONE and set done=1. Otherwise go to GAP with cnt=0.
  - Otherwise cnt increments. On the cycle with cnt = 2^TIMEOUT_BITS−1, a timeout occurs: err_timeout=1, timeout_stage=stage, restart.
- GAP: cnt increments. On the cycle with cnt = STAGE_GAP−1, stage increments and the FSM goes to WAIT_RDY with cnt=0.
- DONE: holds. done=1, and all rst_out are 0.
- Restart:
  - Next state is HOLD with cnt=0 and stage=0.
  - All rst_out go to 1 and done goes to 0.
  - restart_count increments (saturating).
  - err_timeout and timeout_stage are kept.
- Restart triggers, in any state other than HOLD:
  - (a) `req_f`=1.
  - (b) synchronised ready[j]=0 for any stage j that is already released (rst_out[j]=0).
  - (c) timeout.
- In HOLD, `req_f` only freezes the counter; it does not count as a restart.
- Priority: `reset` > req > ready loss > timeout > normal transition. Simultaneous events count as one restart.
- A stage's ready that drops before release has no effect; WAIT_RDY simply continues waiting for it.

## Timing
- Edge numbering: edge 1 is the first rising edge that samples `reset`=0.
- With all synchronised ready already high:
  - rst_out[0] falls after edge 2^DEBOUNCE_BITS+1.
  - rst_out[i] falls STAGE_GAP+1 edges after rst_out[i−1].
  - done rises on the same edge as rst_out[CHANNELS−1] falls.
- A ready rise that arrives while the FSM waits on that stage deasserts its rst_out SYNC_STAGES+1 edges after the input changes.
- A ready loss on a released stage asserts all rst_out SYNC_STAGES+1 edges after the input changes.
- A request asserts all rst_out SYNC_STAGES+REQ_FILTER edges after `req_async` rises.
- Timeout: the FSM spends exactly 2^TIMEOUT_BITS edges in WAIT_RDY before restarting.
- `reset` mid-operation returns every register to its reset value on the next edge.
- rst_out bits only ever deassert in index order, one at a time. All bits assert together.

## Test plan
Common parameters: CHANNELS=3, SYNC_STAGES=2, DEBOUNCE_BITS=4, STAGE_GAP=2, TIMEOUT_BITS=5, REQ_FILTER=4.

1. All ready_async=1 before reset release -> rst_out[0] falls at edge 17, rst_out[1] at 20, rst_out[2] at 23; done=1 at 23; restart_count=0.
2. ready_async[1] tied 0 -> after rst_out[0] falls, 32 edges in WAIT_RDY. Then: rst_out=3'b111, err_timeout=1, timeout_stage=1, restart_count=1, and the sequence repeats.
3. In DONE, a 3-cycle req_async pulse -> no change. A 10-cycle req_async pulse -> rst_out=3'b111 6 edges after the rise. HOLD counter stays frozen while the request is high. Full re-release follows, and restart_count increments by 1.
4. In DONE, ready_async[0] drops for 1 cycle -> rst_out=3'b111 and done=0 3 edges later, restart_count+1. Resequencing starts once ready is high again.
5. `reset` asserted during GAP after stage 0 releases -> next edge gives rst_out=3'b111, done=0, err_timeout=0, restart_count=0. Sequencing then restarts with the timing of scenario 1.
